// File: rtl/svfloat_div_iter.sv
// Iterative floating-point divider front-end. Produces sign, unbiased exponent
// and a frac+1 bit truncated quotient mantissa for a downstream float packer.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;
endpackage

module svfloat_div_iter #(
  parameter type         float  = svfloat::float32,
  parameter int unsigned frac   = 25,
  parameter int unsigned ewidth = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  float                     a,
  input  float                     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     is_zero,
  output logic                     d_sign,
  output logic signed [ewidth-1:0] d_exp,
  output logic [frac:0]            d_man
);

  float r_a, r_b;

  localparam int unsigned EW   = $bits(r_a.exp);
  localparam int unsigned MW   = $bits(r_a.man);
  localparam int unsigned BIAS = (32'd1 << (EW - 1)) - 32'd1;
  localparam int unsigned CW   = $clog2(frac + 1);
  localparam logic signed [ewidth-1:0] EBIAS = ewidth'(BIAS);
  localparam logic signed [ewidth-1:0] EMIN  = ewidth'(1) - EBIAS;

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;
  state_t r_state, w_next;

  logic                     r_inf, r_nan, r_zero, r_sign;
  logic signed [ewidth-1:0] r_exp;
  logic [frac:0]            r_man;
  logic [MW+1:0]            r_rem;
  logic [MW:0]              r_div;
  logic [CW-1:0]            r_cnt;

  logic w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic w_nan, w_inf, w_zero, w_special, w_accept, w_ge;
  logic [MW:0]              w_ma, w_mb;
  logic signed [ewidth-1:0] w_ea, w_eb;
  logic [MW+1:0]            w_sub;

  // Denormals are shifted left until the hidden-bit position is set; the
  // exponent absorbs the shift so the quotient always lies in (0.5, 2).
  function automatic void unpack(input float f, output logic [MW:0] m,
                                 output logic signed [ewidth-1:0] e);
    logic [MW:0] m0;
    int unsigned lz;
    lz = 0;
    m0 = {1'b0, f.man};
    if (f.exp != '0) begin
      m = {1'b1, f.man};
      e = ewidth'(f.exp) - EBIAS;
    end else begin
      for (int unsigned i = 0; i <= MW; i++)
        if (m0[i]) lz = MW - i;
      m = m0 << lz;
      e = EMIN - ewidth'(lz);
    end
  endfunction

  always_comb begin
    w_a_nan   = (&a.exp) && (a.man != '0);
    w_a_inf   = (&a.exp) && (a.man == '0);
    w_a_zero  = (a.exp == '0) && (a.man == '0);
    w_b_nan   = (&b.exp) && (b.man != '0);
    w_b_inf   = (&b.exp) && (b.man == '0);
    w_b_zero  = (b.exp == '0) && (b.man == '0);
    w_nan     = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    w_inf     = !w_nan && (w_a_inf || w_b_zero);
    w_zero    = !w_nan && !w_inf && (w_a_zero || w_b_inf);
    w_special = w_nan || w_inf || w_zero;
    w_accept  = in_valid && (r_state == IDLE);
    unpack(r_a, w_ma, w_ea);
    unpack(r_b, w_mb, w_eb);
    w_ge  = r_rem >= {1'b0, r_div};
    w_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = w_special ? DONE : NORM;
      NORM: w_next = DIV;
      DIV:  if (r_cnt == '0) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_inf  <= 1'b0;
      r_nan  <= 1'b0;
      r_zero <= 1'b0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_man  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_nan  <= w_nan;
        r_inf  <= w_inf;
        r_zero <= w_zero;
        r_sign <= a.sign ^ b.sign;
        r_exp  <= '0;
        r_man  <= '0;
      end
      if (r_state == NORM) begin
        r_exp <= w_ea - w_eb;
        r_rem <= (MW + 2)'(w_ma);
        r_div <= w_mb;
        r_man <= '0;
        r_cnt <= CW'(frac);
      end
      if (r_state == DIV) begin
        r_rem <= w_sub << 1;
        r_man <= {r_man[frac-1:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign is_inf    = r_inf;
  assign is_nan    = r_nan;
  assign is_zero   = r_zero;
  assign d_sign    = r_sign;
  assign d_exp     = r_exp;
  assign d_man     = r_man;

endmodule

// File: tb/tb_svfloat_div_iter.sv
// Directed bench for svfloat_div_iter: latency, quotient fields, specials,
// output backpressure and mid-division reset.
module tb_svfloat_div_iter;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        is_inf, is_nan, is_zero, d_sign;
  logic signed [9:0] d_exp;
  logic [25:0] d_man;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  svfloat_div_iter #(.frac(25), .ewidth(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .is_inf(is_inf), .is_nan(is_nan), .is_zero(is_zero),
    .d_sign(d_sign), .d_exp(d_exp), .d_man(d_man)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb);
    a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
  endtask

  // Counts edges after the accepting edge until out_valid rises.
  task automatic wait_done(input string tag, input int lat_exp);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
  endtask

  task automatic expect_res(input string tag, input logic s, input int e,
                            input logic [25:0] m, input logic [2:0] fl);
    check({tag, "_sign"}, 32'(d_sign), 32'(s));
    check({tag, "_exp"},  32'(d_exp), 32'(e));
    check({tag, "_man"},  32'(d_man), 32'(m));
    check({tag, "_flags"}, 32'({is_inf, is_nan, is_zero}), 32'(fl));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovld_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_irdy_set"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                    input int lat, input logic s, input int e,
                    input logic [25:0] m, input logic [2:0] fl);
    issue(va, vb);
    wait_done(tag, lat);
    expect_res(tag, s, e, m, fl);
    release_out(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_irdy", 32'(in_ready), 32'd1);
    check("rst_ovld", 32'(out_valid), 32'd0);
    expect_res("rst", 1'b0, 0, 26'd0, 3'b000);

    // flags ordering: {is_inf, is_nan, is_zero}
    op("six_two",  32'h40C00000, 32'h40000000, 27, 1'b0,    1, 26'h3000000, 3'b000);
    op("one_3rd",  32'h3F800000, 32'h40400000, 27, 1'b0,   -1, 26'h1555555, 3'b000);
    op("min_den",  32'h00000001, 32'h3F800000, 27, 1'b0, -149, 26'h2000000, 3'b000);
    op("max_den",  32'h7F7FFFFF, 32'h00000001, 27, 1'b0,  276, 26'h3FFFFFC, 3'b000);
    op("neg_q",    32'hC0C00000, 32'h40000000, 27, 1'b1,    1, 26'h3000000, 3'b000);
    op("div_nzero",32'h3F800000, 32'h80000000,  0, 1'b1,    0, 26'd0,       3'b100);
    op("zero_zero",32'h00000000, 32'h00000000,  0, 1'b0,    0, 26'd0,       3'b010);
    op("inf_inf",  32'h7F800000, 32'h7F800000,  0, 1'b0,    0, 26'd0,       3'b010);
    op("qnan",     32'h7FC00000, 32'h3F800000,  0, 1'b0,    0, 26'd0,       3'b010);
    op("by_inf",   32'h3F800000, 32'h7F800000,  0, 1'b0,    0, 26'd0,       3'b001);

    // Backpressure: result held, new requests ignored.
    issue(32'h40C00000, 32'h40000000);
    wait_done("bp", 27);
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_ovld", 32'(out_valid), 32'd1);
      check("bp_irdy", 32'(in_ready), 32'd0);
      check("bp_man",  32'(d_man), 32'h3000000);
      check("bp_exp",  32'(d_exp), 32'd1);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Reset ten cycles into a division discards it.
    issue(32'h3F800000, 32'h40400000);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ovld", 32'(out_valid), 32'd0);
    check("mid_rst_irdy", 32'(in_ready), 32'd1);
    expect_res("mid_rst", 1'b0, 0, 26'd0, 3'b000);
    op("after_rst", 32'h40C00000, 32'h40000000, 27, 1'b0, 1, 26'h3000000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
